// File: rtl/framebuffer_stripe_sequencer_if.sv
// Command port between the stripe sequencer (master) and the internal framebuffer (slave).
// Handshake: master holds fb_apply with stable cmd bits until it samples fb_applied low, then drops them;
// the command is complete only when fb_applied is subsequently sampled high again.
interface framebuffer_stripe_sequencer_if #(
  parameter int Y_BIT_WIDTH         = 11,
  parameter int FB_SIZE_IN_PIXEL_LG = 20
);
  logic                           fb_apply;
  logic                           fb_applied;
  logic                           fb_cmdCommit;
  logic                           fb_cmdMemset;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_cmdSize;
  logic [Y_BIT_WIDTH-1:0]         fb_confYOffset;

  modport master (
    output fb_apply, fb_cmdCommit, fb_cmdMemset, fb_cmdSize, fb_confYOffset,
    input  fb_applied
  );

  modport slave (
    input  fb_apply, fb_cmdCommit, fb_cmdMemset, fb_cmdSize, fb_confYOffset,
    output fb_applied
  );
endinterface

// File: rtl/framebuffer_stripe_sequencer.sv
// Sequences the framebuffer through one frame in horizontal stripes:
// optional memset, render window for the rasterizer, then commit at the stripe's Y offset.
module framebuffer_stripe_sequencer #(
  parameter int Y_BIT_WIDTH         = 11,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int STRIPE_CNT_WIDTH    = 8
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           cfgClear,
  input  logic [STRIPE_CNT_WIDTH-1:0]    cfgNumStripes,
  input  logic [Y_BIT_WIDTH-1:0]         cfgStripeHeight,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] cfgStripeSize,
  output logic                           busy,
  output logic                           frameDone,
  output logic                           renderStart,
  input  logic                           renderDone,
  output logic [STRIPE_CNT_WIDTH-1:0]    stripeIdx,
  framebuffer_stripe_sequencer_if.master fb,
  output logic [2:0]                     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR_REQ  = 3'd1,
    S_CLR_WAIT = 3'd2,
    S_RENDER   = 3'd3,
    S_CMT_REQ  = 3'd4,
    S_CMT_WAIT = 3'd5,
    S_NEXT     = 3'd6
  } state_e;

  state_e                         state_q, state_d;
  logic                           busy_q, busy_d;
  logic                           frame_done_q, frame_done_d;
  logic                           render_start_q, render_start_d;
  logic                           rs_issued_q, rs_issued_d;
  logic                           apply_q, apply_d;
  logic                           commit_q, commit_d;
  logic                           memset_q, memset_d;
  logic                           clear_q, clear_d;
  logic [STRIPE_CNT_WIDTH-1:0]    num_q, num_d;
  logic [STRIPE_CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [Y_BIT_WIDTH-1:0]         height_q, height_d;
  logic [Y_BIT_WIDTH-1:0]         yoff_q, yoff_d;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] size_q, size_d;

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    frame_done_d   = 1'b0;
    render_start_d = 1'b0;
    rs_issued_d    = rs_issued_q;
    clear_d        = clear_q;
    num_d          = num_q;
    idx_d          = idx_q;
    height_d       = height_q;
    yoff_d         = yoff_q;
    size_d         = size_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfgNumStripes == '0) begin
            frame_done_d = 1'b1;
          end else begin
            clear_d  = cfgClear;
            num_d    = cfgNumStripes;
            height_d = cfgStripeHeight;
            size_d   = cfgStripeSize;
            idx_d    = '0;
            yoff_d   = '0;
            busy_d   = 1'b1;
            state_d  = cfgClear ? S_CLR_REQ : S_RENDER;
          end
        end
      end
      S_CLR_REQ:  if (!fb.fb_applied) state_d = S_CLR_WAIT;
      S_CLR_WAIT: if (fb.fb_applied)  state_d = S_RENDER;
      S_RENDER: begin
        // renderDone only counts once the grant pulse is on the wire, including its own cycle.
        if (!rs_issued_q) begin
          render_start_d = 1'b1;
          rs_issued_d    = 1'b1;
        end else if (renderDone) begin
          state_d = S_CMT_REQ;
        end
      end
      S_CMT_REQ:  if (!fb.fb_applied) state_d = S_CMT_WAIT;
      S_CMT_WAIT: if (fb.fb_applied)  state_d = S_NEXT;
      S_NEXT: begin
        if (idx_q == num_q - 1'b1) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          yoff_d  = yoff_q + height_q;
          state_d = clear_q ? S_CLR_REQ : S_RENDER;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_RENDER) rs_issued_d = 1'b0;

    // Command outputs are decoded from the next state so they are registered alongside it.
    apply_d  = (state_d == S_CLR_REQ) || (state_d == S_CMT_REQ);
    memset_d = (state_d == S_CLR_REQ);
    commit_d = (state_d == S_CMT_REQ);
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      render_start_q <= 1'b0;
      rs_issued_q    <= 1'b0;
      apply_q        <= 1'b0;
      commit_q       <= 1'b0;
      memset_q       <= 1'b0;
      clear_q        <= 1'b0;
      num_q          <= '0;
      idx_q          <= '0;
      height_q       <= '0;
      yoff_q         <= '0;
      size_q         <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      render_start_q <= render_start_d;
      rs_issued_q    <= rs_issued_d;
      apply_q        <= apply_d;
      commit_q       <= commit_d;
      memset_q       <= memset_d;
      clear_q        <= clear_d;
      num_q          <= num_d;
      idx_q          <= idx_d;
      height_q       <= height_d;
      yoff_q         <= yoff_d;
      size_q         <= size_d;
    end
  end

  assign busy              = busy_q;
  assign frameDone         = frame_done_q;
  assign renderStart       = render_start_q;
  assign stripeIdx         = idx_q;
  assign fb.fb_apply       = apply_q;
  assign fb.fb_cmdCommit   = commit_q;
  assign fb.fb_cmdMemset   = memset_q;
  assign fb.fb_cmdSize     = size_q;
  assign fb.fb_confYOffset = yoff_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_framebuffer_stripe_sequencer.sv
// Directed bench: framebuffer and rasterizer models, event-order scoreboard and commit expectation queue.
module tb_framebuffer_stripe_sequencer;
  localparam int YW = 11;
  localparam int SW = 20;
  localparam int CW = 8;
  localparam logic [7:0] EV_M = 8'h4d;
  localparam logic [7:0] EV_R = 8'h52;
  localparam logic [7:0] EV_C = 8'h43;
  localparam logic [7:0] EV_D = 8'h44;
  localparam logic [7:0] EV_X = 8'h3f;

  // clock / reset
  logic aclk = 1'b0;
  logic resetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          start = 1'b0;
  logic          cfgClear = 1'b0;
  logic [CW-1:0] cfgNumStripes = '0;
  logic [YW-1:0] cfgStripeHeight = '0;
  logic [SW-1:0] cfgStripeSize = '0;
  logic          busy, frameDone, renderStart, renderDone;
  logic [CW-1:0] stripeIdx;
  logic [2:0]    dbg_state;

  framebuffer_stripe_sequencer_if #(.Y_BIT_WIDTH(YW), .FB_SIZE_IN_PIXEL_LG(SW)) fb ();

  framebuffer_stripe_sequencer #(
    .Y_BIT_WIDTH(YW), .FB_SIZE_IN_PIXEL_LG(SW), .STRIPE_CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .resetn(resetn), .start(start), .cfgClear(cfgClear),
    .cfgNumStripes(cfgNumStripes), .cfgStripeHeight(cfgStripeHeight),
    .cfgStripeSize(cfgStripeSize), .busy(busy), .frameDone(frameDone),
    .renderStart(renderStart), .renderDone(renderDone), .stripeIdx(stripeIdx),
    .fb(fb), .dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]        exp_ev_q[$];
  logic [CW+YW+SW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ev(input logic [7:0] c);
    if (exp_ev_q.size() == 0) check("ev_extra", {56'd0, c}, 64'd0);
    else check("ev_order", {56'd0, c}, {56'd0, exp_ev_q.pop_front()});
  endtask

  // framebuffer / rasterizer models and monitor
  int   drop_dly = 1, hi_dly = 1, render_dly = 3;
  bit   inject_en = 1'b0, injected = 1'b0, last_memset = 1'b0, prev_apply = 1'b0;
  int   fbs = 0, fcnt = 0, rcnt = -1;
  int   run = 0, max_run = 0, n_apply = 0, n_busy_hi = 0;
  logic applied_m = 1'b1, raster_done = 1'b0, inject_done = 1'b0;
  assign fb.fb_applied = applied_m;
  assign renderDone = raster_done | inject_done;

  always @(negedge aclk or negedge resetn) begin
    if (!resetn) begin
      applied_m = 1'b1; fbs = 0; fcnt = 0; rcnt = -1; run = 0; prev_apply = 1'b0;
      raster_done = 1'b0; inject_done = 1'b0;
    end else begin
      case (fbs)
        0: if (fb.fb_apply && applied_m) begin
             fcnt++;
             if (fcnt >= drop_dly) begin applied_m = 1'b0; fbs = 1; fcnt = 0; end
           end
        1: if (!fb.fb_apply) begin fbs = 2; fcnt = 0; end
        default: begin
          fcnt++;
          if (fcnt >= hi_dly) begin applied_m = 1'b1; fbs = 0; fcnt = 0; end
        end
      endcase
      inject_done = 1'b0;
      if (inject_en && !injected && fbs == 2 && last_memset) begin
        inject_done = 1'b1; injected = 1'b1;
      end
      raster_done = 1'b0;
      if (renderStart) rcnt = render_dly;
      if (rcnt == 0) begin raster_done = 1'b1; rcnt = -1; end
      else if (rcnt > 0) rcnt--;

      if (renderStart) ev(EV_R);
      if (fb.fb_apply && !prev_apply) begin
        n_apply++;
        check("cmd_excl", {63'd0, fb.fb_cmdMemset & fb.fb_cmdCommit}, 64'd0);
        last_memset = fb.fb_cmdMemset;
        if (fb.fb_cmdMemset) ev(EV_M);
        else if (fb.fb_cmdCommit) begin
          ev(EV_C);
          if (exp_q.size() == 0) check("commit_extra", 64'd1, 64'd0);
          else check("commit_idx_y_size", {25'd0, stripeIdx, fb.fb_confYOffset, fb.fb_cmdSize},
                     {25'd0, exp_q.pop_front()});
        end else ev(EV_X);
      end
      if (fb.fb_apply) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (frameDone) ev(EV_D);
      if (busy) n_busy_hi++;
      prev_apply = fb.fb_apply;
    end
  end

  // driver tasks
  task automatic expect_frame(input bit clr, input int n, input logic [YW-1:0] h, input logic [SW-1:0] sz);
    logic [YW-1:0] y;
    y = '0;
    for (int i = 0; i < n; i++) begin
      if (clr) exp_ev_q.push_back(EV_M);
      exp_ev_q.push_back(EV_R);
      exp_ev_q.push_back(EV_C);
      exp_q.push_back({i[CW-1:0], y, sz});
      y = y + h;
    end
    exp_ev_q.push_back(EV_D);
  endtask

  // Called at a negedge; start is held for exactly one cycle. Returns cycle indices of first events.
  task automatic run_frame(input bit clr, input int n, input logic [YW-1:0] h, input logic [SW-1:0] sz,
                           input int inj, output int k_rs, output int k_ap, output int k_dn,
                           output bit busy1);
    int k;
    expect_frame(clr, n, h, sz);
    cfgClear = clr; cfgNumStripes = n[CW-1:0]; cfgStripeHeight = h; cfgStripeSize = sz;
    n_apply = 0; n_busy_hi = 0; max_run = 0;
    k = 0; k_rs = -1; k_ap = -1; k_dn = -1; busy1 = 1'b0;
    start = 1'b1;
    while (k_dn < 0 && k < 2000) begin
      @(negedge aclk);
      k++;
      start = (k == inj);
      if (k == inj) begin cfgNumStripes = cfgNumStripes + 8'd5; cfgStripeHeight = cfgStripeHeight + 11'd3; end
      if (k == 1) busy1 = busy;
      if (renderStart && k_rs < 0) k_rs = k;
      if (fb.fb_apply && k_ap < 0) k_ap = k;
      if (frameDone) k_dn = k;
    end
    start = 1'b0;
    check("frame_done_seen", {63'd0, k_dn > 0}, 64'd1);
    @(negedge aclk);
    check("done_one_pulse", {63'd0, frameDone}, 64'd0);
    check("busy_after_frame", {63'd0, busy}, 64'd0);
    check("ev_left", exp_ev_q.size(), 64'd0);
    check("commit_left", exp_q.size(), 64'd0);
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int  k_rs, k_ap, k_dn, k;
    bit  busy1;

    repeat (3) @(negedge aclk);
    check("rst_outputs", {busy, frameDone, renderStart, stripeIdx, fb.fb_apply, fb.fb_cmdCommit,
                          fb.fb_cmdMemset, fb.fb_cmdSize, fb.fb_confYOffset}, 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge aclk);

    // single stripe, no clear, fast drop / 10-cycle raise, same-cycle renderDone
    drop_dly = 1; hi_dly = 10; render_dly = 0;
    run_frame(1'b0, 1, 11'd16, 20'd4096, -1, k_rs, k_ap, k_dn, busy1);
    check("t1_busy_after_start", {63'd0, busy1}, 64'd1);
    check("t1_start_to_rs", k_rs, 64'd2);
    check("t1_rd_to_apply", k_ap - k_rs, 64'd1);
    check("t1_n_apply", n_apply, 64'd1);
    check("t1_idx_final", stripeIdx, 64'd0);

    // three stripes with clear
    drop_dly = 1; hi_dly = 2; render_dly = 3;
    run_frame(1'b1, 3, 11'd80, 20'd1000, -1, k_rs, k_ap, k_dn, busy1);
    check("t2_n_apply", n_apply, 64'd6);
    check("t2_idx_final", stripeIdx, 64'd2);
    check("t2_yoff_final", fb.fb_confYOffset, 64'd160);

    // slow framebuffer, stray renderDone during CLR_WAIT
    drop_dly = 5; hi_dly = 3; render_dly = 2; inject_en = 1'b1; injected = 1'b0;
    run_frame(1'b1, 2, 11'd40, 20'd512, -1, k_rs, k_ap, k_dn, busy1);
    inject_en = 1'b0;
    check("t3_injected", {63'd0, injected}, 64'd1);
    check("t3_apply_hold_ge5", {63'd0, max_run >= 5}, 64'd1);
    check("t3_n_apply", n_apply, 64'd4);

    // zero stripes
    drop_dly = 1; hi_dly = 2;
    run_frame(1'b1, 0, 11'd8, 20'd64, -1, k_rs, k_ap, k_dn, busy1);
    check("t4_done_latency", k_dn, 64'd1);
    check("t4_busy_never", n_busy_hi, 64'd0);
    check("t4_no_apply", n_apply, 64'd0);

    // start and config changes while busy are ignored
    run_frame(1'b0, 2, 11'd30, 20'd300, 8, k_rs, k_ap, k_dn, busy1);
    check("t5_n_apply", n_apply, 64'd2);
    check("t5_idx_final", stripeIdx, 64'd1);

    // Y offset wrap
    run_frame(1'b0, 3, 11'd1024, 20'd2048, -1, k_rs, k_ap, k_dn, busy1);
    check("t6_yoff_final", fb.fb_confYOffset, 64'd0);

    // reset during CMT_REQ, then a clean frame
    drop_dly = 4; hi_dly = 2;
    expect_frame(1'b0, 2, 11'd5, 20'd77);
    cfgClear = 1'b0; cfgNumStripes = 8'd2; cfgStripeHeight = 11'd5; cfgStripeSize = 20'd77;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    k = 0;
    while (!(fb.fb_apply && fb.fb_cmdCommit) && k < 100) begin @(negedge aclk); k++; end
    check("t7_reach_cmt", {63'd0, fb.fb_apply & fb.fb_cmdCommit}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("t7_async_rst_outputs", {busy, frameDone, renderStart, stripeIdx, fb.fb_apply, fb.fb_cmdCommit,
                                   fb.fb_cmdMemset, fb.fb_cmdSize, fb.fb_confYOffset}, 64'd0);
    exp_ev_q.delete();
    exp_q.delete();
    repeat (3) @(negedge aclk);
    check("t7_no_done_in_rst", {63'd0, frameDone}, 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge aclk);
    drop_dly = 1; hi_dly = 2;
    run_frame(1'b1, 2, 11'd64, 20'd999, -1, k_rs, k_ap, k_dn, busy1);
    check("t7_n_apply", n_apply, 64'd4);
    check("t7_yoff_final", fb.fb_confYOffset, 64'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
